// File: rtl/accum_sequencer_if.sv
// Control and handshake bundle between the accumulate-loop sequencer and
// its surroundings: run request/limit/abort in, datapath selects and
// enables plus run status out.
interface accum_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] limit;
    logic             abort;
    logic             sum_cout;
    logic             nSel;
    logic             sumSel;
    logic             adderMuxSel;
    logic             nEn;
    logic             sumEn;
    logic             outBuf;
    logic             busy;
    logic             done;
    logic             ovf;

    // Requester/datapath side: issues runs, returns the adder carry.
    modport master (
        output start, limit, abort, sum_cout,
        input  nSel, sumSel, adderMuxSel, nEn, sumEn, outBuf, busy, done, ovf
    );

    // Sequencer side: consumes requests, drives every datapath control.
    modport slave (
        input  start, limit, abort, sum_cout,
        output nSel, sumSel, adderMuxSel, nEn, sumEn, outBuf, busy, done, ovf
    );
endinterface

// File: rtl/accum_sequencer.sv
// Moore control unit for the accumulate-loop datapath. Runs
// sum = 1 + 2 + ... + L on request, loads the output buffer, pulses done,
// and keeps a sticky flag if the datapath adder carried out during the run.
module accum_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    accum_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        INC  = 3'd2,
        ADD  = 3'd3,
        OUT  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t           state;
    state_t           nextState;
    logic [CNT_W-1:0] limitQ;
    logic [CNT_W-1:0] cnt;
    logic             ovfQ;
    logic             abortable;

    // An abort only cancels a run from the working states; IDLE and DONE ignore it.
    assign abortable = bus.abort &&
                       ((state == INIT) || (state == INC) ||
                        (state == ADD)  || (state == OUT));

    assign bus.ovf = ovfQ;

    // State register, forced back to IDLE the moment reset asserts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Loop limit capture, iteration count and sticky overflow; an aborted cycle leaves ovf untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            limitQ <= '0;
            cnt    <= '0;
            ovfQ   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        limitQ <= bus.limit;
                    end
                end
                INIT: begin
                    if (!bus.abort) begin
                        cnt  <= '0;
                        ovfQ <= 1'b0;
                    end
                end
                INC: begin
                    cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                ADD: begin
                    if (!bus.abort && bus.sum_cout) begin
                        ovfQ <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state selection plus datapath controls decoded from the current state only.
    always_comb begin
        nextState       = IDLE;
        bus.nSel        = 1'b0;
        bus.sumSel      = 1'b0;
        bus.adderMuxSel = 1'b0;
        bus.nEn         = 1'b0;
        bus.sumEn       = 1'b0;
        bus.outBuf      = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        case (state)
            IDLE: begin
                nextState = bus.start ? INIT : IDLE;
            end
            INIT: begin
                bus.busy  = 1'b1;
                bus.nEn   = 1'b1;
                bus.sumEn = 1'b1;
                nextState = (limitQ == '0) ? OUT : INC;
            end
            INC: begin
                bus.busy        = 1'b1;
                bus.adderMuxSel = 1'b1;
                bus.nSel        = 1'b1;
                bus.nEn         = 1'b1;
                nextState       = ADD;
            end
            ADD: begin
                bus.busy   = 1'b1;
                bus.sumSel = 1'b1;
                bus.sumEn  = 1'b1;
                nextState  = (cnt == limitQ) ? OUT : INC;
            end
            OUT: begin
                bus.busy   = 1'b1;
                bus.outBuf = 1'b1;
                nextState  = DONE;
            end
            DONE: begin
                bus.busy  = 1'b1;
                bus.done  = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        if (abortable) begin
            nextState = IDLE;
        end
    end

endmodule

// File: doc/accum_sequencer.md
# accum_sequencer

Moore-style control unit for the accumulate-loop datapath (n register, sum register, shared adder with operand mux, output buffer). It replaces the fixed 1-to-10 loop with a start/done handshake and a run-time loop limit. It sequences the datapath to compute sum = 1 + 2 + … + L, reports the result through the datapath output buffer, and flags adder overflow. It sits beside the datapath under the top level and drives all of the datapath's select and enable lines.

## Interface
- CNT_W, 8, width of loop limit and internal iteration counter
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request a run; sampled only in IDLE
- limit  in  CNT_W  loop bound L; latched into limit_q when start is accepted
- abort  in  1  cancel a run in progress
- sum_cout  in  1  carry-out of the datapath adder (valid when sumEn=1)
- nSel  out  1  0: n register loads 0; 1: n register loads adder result
- sumSel  out  1  0: sum register loads 0; 1: sum register loads adder result
- adderMuxSel  out  1  0: adder = sum + n; 1: adder = n + 1
- nEn  out  1  n register load enable
- sumEn  out  1  sum register load enable
- outBuf  out  1  output buffer load enable (outPort <= sum)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a run completes normally
- ovf  out  1  sticky overflow of the most recent run

## Operation
- Internal state: FSM state, limit_q[CNT_W], cnt[CNT_W], ovf.
- States and outputs (unlisted outputs are 0):
  - IDLE: no datapath writes. If start=1, latch limit_q=limit and go to INIT.
  - INIT: nSel=0, sumSel=0, nEn=1, sumEn=1. Clear cnt=0 and ovf=0. If limit_q==0, go to OUT; otherwise go to INC.
  - INC: adderMuxSel=1, nSel=1, nEn=1 (n <= n+1). Set cnt <= cnt+1. Go to ADD.
  - ADD: adderMuxSel=0, sumSel=1, sumEn=1 (sum <= sum+n). If sum_cout=1, set ovf <= 1. If cnt==limit_q, go to OUT; otherwise go to INC.
  - OUT: outBuf=1. Go to DONE.
  - DONE: done=1. Go to IDLE.
- abort=1 in INIT, INC, ADD or OUT:
  - The FSM goes to IDLE on the next edge.
  - abort has priority over all other transitions.
  - Datapath control outputs in the abort cycle still follow the current state.
  - done is not pulsed, and ovf keeps its value.
- abort in IDLE or DONE is ignored.
- start outside IDLE is ignored; it is not queued. Changes to limit outside IDLE have no effect.
- ovf is sticky from the first carry until the next INIT. It is readable after done.
- cnt arithmetic is modulo 2^CNT_W. It cannot wrap, because the loop exits at cnt==limit_q ≤ 2^CNT_W−1.
- Unreachable state encodings return to IDLE.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, limit_q=0, ovf=0. Every output is 0 while reset is held and after release.
- Outputs are decoded from the state register only (Moore). They take no combinational path from start, limit or abort.
- Let cycle 0 be the cycle in which start=1 is sampled in IDLE:
  - INIT occupies cycle 1.
  - For iteration k (1..L), INC occupies cycle 2k and ADD occupies cycle 2k+1.
  - OUT occupies cycle 2L+2, and outPort shows the sum from cycle 2L+3.
  - done=1 in cycle 2L+3, and the FSM is back in IDLE at cycle 2L+4.
- A new start is accepted in cycle 2L+4 at the earliest, giving back-to-back runs.
- busy=1 from cycle 1 through cycle 2L+3 inclusive.
- Reset asserted mid-run returns everything to the reset values immediately. Datapath registers are not cleared by this block; the next INIT clears them.

## Test plan
- Reset, then limit=10 with a 1-cycle start pulse -> outPort=55, done pulses exactly once at cycle 23, ovf=0, busy is low at cycle 24.
- limit=0 -> INIT goes directly to OUT, outPort=0, done at cycle 3, no INC/ADD enables are observed.
- With an 8-bit datapath: limit=22 -> outPort=253, ovf=0. Then limit=23 -> outPort=20 (276 mod 256), ovf=1. A following limit=3 run -> outPort=6, ovf=0.
- Run with limit=10 and abort=1 in cycle 9 (INC or ADD) -> IDLE at cycle 10, no done, no outBuf pulse. A subsequent limit=4 run -> outPort=10.
- During a limit=5 run, pulse start with limit=2 at cycle 4 -> ignored, result is 15, done at cycle 13.
- rst low at cycle 6 of a limit=10 run -> all outputs 0 immediately. After release, a start with limit=10 -> outPort=55.
